// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared types for the ID->EX stage: control bus layout, ALU intent encoding, halt FSM states.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_RTY = 2'b10,
        ALU_ITY = 2'b11
    } alu_intent_t;

    typedef struct packed {
        logic        is_halt;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        mem_write_en;
        logic        mem_read_en;
        logic        reg_write_en;
        logic        rd_src_optn;
        alu_intent_t alu_intent;
        logic        alu_src_optn;
    } ctrl_bus_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } halt_state_t;

    localparam ctrl_bus_t CTRL_NOP = '0;

    // x0 is hardwired to zero, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// ID->EX stage bundle: ID-side fields and pipeline controls in, EX-side fields and hazard/halt status out.
interface id_ex_pipeline_reg_if
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            stall_i;
    logic            flush_i;
    logic            id_valid_i;
    ctrl_bus_t       id_ctrl_i;
    logic [XLEN-1:0] id_pc_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [4:0]      id_rs1_addr_i;
    logic [4:0]      id_rs2_addr_i;
    logic [4:0]      id_rd_addr_i;
    logic [2:0]      id_funct3_i;
    logic            id_funct7_b5_i;

    logic            ex_valid_o;
    ctrl_bus_t       ex_ctrl_o;
    logic [XLEN-1:0] ex_pc_o;
    logic [XLEN-1:0] ex_rs1_data_o;
    logic [XLEN-1:0] ex_rs2_data_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [4:0]      ex_rs1_addr_o;
    logic [4:0]      ex_rs2_addr_o;
    logic [4:0]      ex_rd_addr_o;
    logic [2:0]      ex_funct3_o;
    logic            ex_funct7_b5_o;
    logic            load_use_stall_o;
    logic            halt_pending_o;
    logic            core_halted_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_ctrl_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
               id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_funct3_i, id_funct7_b5_i,
        input  ex_valid_o, ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_funct3_o, ex_funct7_b5_o,
               load_use_stall_o, halt_pending_o, core_halted_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_ctrl_i, id_pc_i, id_rs1_data_i, id_rs2_data_i,
               id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_funct3_i, id_funct7_b5_i,
        output ex_valid_o, ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_funct3_o, ex_funct7_b5_o,
               load_use_stall_o, halt_pending_o, core_halted_o
    );

endinterface

// File: rtl/id_ex_pipeline_reg_load_use_detector.sv
// Load-use hazard detect: a load in EX whose rd feeds either source of the ID instruction.
// Purely combinational; both sources are compared regardless of instruction format.
module load_use_detector
    import core_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    output logic       hazard_o
);

    assign hazard_o = id_valid_i & ex_valid_i & ex_mem_read_i
                    & (reg_match(ex_rd_addr_i, id_rs1_addr_i) | reg_match(ex_rd_addr_i, id_rs2_addr_i));

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID->EX pipeline register with bubble insertion, load-use detect and post-ecall halt drain; 1-cycle latency,
// stall_i holds everything. Optional ID_EX_PERF_CNT_EN adds saturating bubble/stall counters.
module id_ex_pipeline_reg
    import core_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    id_ex_pipeline_reg_if.slave  pipe
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          bubble_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

    typedef struct packed {
        logic            valid;
        ctrl_bus_t       ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic            funct7_b5;
    } ex_reg_t;

    ex_reg_t     ex_q, ex_d, id_pkt;
    halt_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic        halt_pending_q, core_halted_q;
    logic        hazard_raw, load_use, halt_enter, insert_bubble;

    load_use_detector u_lud (
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ex_q.ctrl.mem_read_en),
        .ex_rd_addr_i  (ex_q.rd_addr),
        .id_valid_i    (pipe.id_valid_i),
        .id_rs1_addr_i (pipe.id_rs1_addr_i),
        .id_rs2_addr_i (pipe.id_rs2_addr_i),
        .hazard_o      (hazard_raw)
    );

    assign load_use   = hazard_raw & (state_q == ST_RUN);
    // The ecall's own edge already blocks the younger instruction sitting in ID
    assign halt_enter = (state_q == ST_RUN) & ex_q.valid & ex_q.ctrl.is_halt;
    assign insert_bubble = (state_q != ST_RUN) | halt_enter | load_use;

    always_comb begin
        id_pkt = '0;
        if (pipe.id_valid_i) begin
            id_pkt.valid     = 1'b1;
            id_pkt.ctrl      = pipe.id_ctrl_i;
            id_pkt.pc        = pipe.id_pc_i;
            id_pkt.rs1_data  = pipe.id_rs1_data_i;
            id_pkt.rs2_data  = pipe.id_rs2_data_i;
            id_pkt.imm       = pipe.id_imm_i;
            id_pkt.rs1_addr  = pipe.id_rs1_addr_i;
            id_pkt.rs2_addr  = pipe.id_rs2_addr_i;
            id_pkt.rd_addr   = pipe.id_rd_addr_i;
            id_pkt.funct3    = pipe.id_funct3_i;
            id_pkt.funct7_b5 = pipe.id_funct7_b5_i;
        end
    end

    always_comb begin
        ex_d = ex_q;
        if (pipe.flush_i) begin
            ex_d = '0;
        end else if (!pipe.stall_i) begin
            ex_d = insert_bubble ? '0 : id_pkt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Halt drain: flush never affects it, stall freezes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            halt_pending_q <= 1'b0;
            core_halted_q  <= 1'b0;
        end else if (!pipe.stall_i) begin
            case (state_q)
                ST_RUN: begin
                    if (halt_enter) begin
                        state_q        <= ST_DRAIN;
                        cnt_q          <= '0;
                        halt_pending_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q       <= ST_HALTED;
                        core_halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q        <= ST_RUN;
                    halt_pending_q <= 1'b0;
                    core_halted_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, stall_cnt_q;
    logic        bubble_evt;

    assign bubble_evt = pipe.flush_i | (!pipe.stall_i & insert_bubble);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (pipe.stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

    assign pipe.ex_valid_o       = ex_q.valid;
    assign pipe.ex_ctrl_o        = ex_q.ctrl;
    assign pipe.ex_pc_o          = ex_q.pc;
    assign pipe.ex_rs1_data_o    = ex_q.rs1_data;
    assign pipe.ex_rs2_data_o    = ex_q.rs2_data;
    assign pipe.ex_imm_o         = ex_q.imm;
    assign pipe.ex_rs1_addr_o    = ex_q.rs1_addr;
    assign pipe.ex_rs2_addr_o    = ex_q.rs2_addr;
    assign pipe.ex_rd_addr_o     = ex_q.rd_addr;
    assign pipe.ex_funct3_o      = ex_q.funct3;
    assign pipe.ex_funct7_b5_o   = ex_q.funct7_b5;
    assign pipe.load_use_stall_o = load_use;
    assign pipe.halt_pending_o   = halt_pending_q;
    assign pipe.core_halted_o    = core_halted_q;

endmodule
